// File: rtl/fifo_uart_tx_if.sv
// FIFO read port between the synchronous FIFO and the UART transmitter.
// Handshake: the consumer raises re for one cycle only while empty was low;
// rd then holds the popped word during the following cycle.
interface fifo_uart_tx_if #(
  parameter int M = 8
);
  logic         empty;
  logic [M-1:0] rd;
  logic         re;

  modport master (input empty, input rd, output re);
  modport slave  (output empty, output rd, input re);
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time and sends each word as a
// serial frame: start bit, M data bits LSB first, optional parity, stop bit.
module fifo_uart_tx #(
  parameter int M            = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_uart_tx_if.master       fifo,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic [2:0]           dbg_state_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_PAR   = 3'd5,
    S_STOP  = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [M-1:0]       shift_q, shift_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               baud_end;
  logic               bit_end;
  logic               counting;

  assign baud_end = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
  assign bit_end  = (bit_q == BIT_W'(M - 1));
  assign counting = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PAR)   || (state_q == S_STOP);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE:  if (!fifo.empty) state_d = S_REQ;
      S_REQ:   state_d = S_LOAD;
      S_LOAD: begin
        shift_d = fifo.rd;
        par_d   = (PARITY == 2) ? ~^fifo.rd : ^fifo.rd;
        state_d = S_START;
      end
      S_START: if (baud_end) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (baud_end) begin
        shift_d = shift_q >> 1;
        if (bit_end) state_d = (PARITY != 0) ? S_PAR : S_STOP;
        else         bit_d   = bit_q + BIT_W'(1);
      end
      S_PAR:   if (baud_end) state_d = S_STOP;
      S_STOP:  if (baud_end) state_d = fifo.empty ? S_IDLE : S_REQ;
      default: state_d = S_IDLE;
    endcase

    // Baud counter restarts on every state entry and at each bit boundary.
    if (!counting || baud_end || (state_d != state_q)) baud_d = '0;
    else                                               baud_d = baud_q + CNT_W'(1);

    // tx is registered, so it is derived from the state being entered.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx          = tx_q;
  assign busy        = (state_q != S_IDLE);
  assign fifo.re     = (state_q == S_REQ);
  assign frame_done  = (state_q == S_STOP) && baud_end;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: instance 0 drains a modelled FIFO (no parity),
// instances 1 and 2 send one word with even and odd parity.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // FIFO model for instance 0: single-writer push/pop counters over a memory
  logic [7:0] mem [0:1023];
  int         push_cnt = 0;
  int         pop_cnt  = 0;
  int         cyc      = 0;
  int         rst_cnt  = 0;
  logic [7:0] rd0      = 8'h00;
  logic       empty_p1 = 1'b1;
  logic       empty_p2 = 1'b1;
  wire        empty0   = (push_cnt == pop_cnt);

  wire  [2:0] empty_w = {empty_p2, empty_p1, empty0};
  wire  [7:0] rd_w [3];
  wire  [2:0] tx_w, busy_w, fd_w, re_w;
  wire  [2:0] st_w [3];

  assign rd_w[0] = rd0;
  assign rd_w[1] = 8'h07;
  assign rd_w[2] = 8'h07;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fifo_uart_tx_if #(.M(8)) bus ();
    assign bus.empty = empty_w[g];
    assign bus.rd    = rd_w[g];
    assign re_w[g]   = bus.re;
    fifo_uart_tx #(.M(8), .CLKS_PER_BIT(CPB), .PARITY(g)) dut (
      .clk         (clk),
      .reset       (reset),
      .fifo        (bus),
      .tx          (tx_w[g]),
      .busy        (busy_w[g]),
      .frame_done  (fd_w[g]),
      .dbg_state_o (st_w[g])
    );
  end

  // scoreboard state
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) rst_cnt <= rst_cnt + 1;
    if (re_w[0]) begin
      check_eq("re_while_empty", 16'(empty0), 16'd0);
      rd0     <= mem[pop_cnt[9:0]];
      pop_cnt <= pop_cnt + 1;
    end
  end

  // driver tasks
  task automatic push(input logic [7:0] d);
    mem[push_cnt[9:0]] = d;
    push_cnt++;
    exp_q.push_back(d);
  endtask

  // Called at the negedge where the start bit is first seen.
  task automatic capture(input int idx, input int nbits, output logic [15:0] bits,
                         output bit clean, output bit fd_ok, output bit aborted);
    int   r0 = rst_cnt;
    logic v;
    bits = '0; clean = 1'b1; fd_ok = 1'b1; aborted = 1'b0;
    for (int s = 0; s < nbits * CPB; s++) begin
      if (s > 0) @(negedge clk);
      if (rst_cnt != r0) begin
        aborted = 1'b1;
        return;
      end
      v = tx_w[idx];
      if (s % CPB == 0) bits[s / CPB] = v;
      else if (v !== bits[s / CPB]) clean = 1'b0;
      if (fd_w[idx] !== (s == nbits * CPB - 1)) fd_ok = 1'b0;
    end
  endtask

  task automatic wait_starts(input int n, input string tag);
    int k = 0;
    while (start_q.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 16'(start_q.size() >= n), 16'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!(exp_q.size() == 0 && st_w[0] == 3'd0 && empty0) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 16'(k < 5000), 16'd1);
  endtask

  task automatic set_empty(input int idx, input logic v);
    if (idx == 1) empty_p1 = v;
    else          empty_p2 = v;
  endtask

  task automatic parity_frame(input int idx, input logic exp_par);
    logic [15:0] bits;
    bit clean, fd_ok, ab;
    int k = 0;
    int res = 0;
    set_empty(idx, 1'b0);
    while (tx_w[idx] !== 1'b0 && k < 200) begin
      @(negedge clk);
      if (re_w[idx]) begin
        res++;
        set_empty(idx, 1'b1);
      end
      k++;
    end
    check_eq("par_start_seen", 16'(k < 200), 16'd1);
    capture(idx, 11, bits, clean, fd_ok, ab);
    check_eq("par_re_pulses", 16'(res), 16'd1);
    check_eq("par_start_bit", 16'(bits[0]), 16'd0);
    check_eq("par_data", 16'(bits[8:1]), 16'h0007);
    check_eq("par_bit", 16'(bits[9]), 16'(exp_par));
    check_eq("par_stop_bit", 16'(bits[10]), 16'd1);
    check_eq("par_bit_stable", 16'(clean), 16'd1);
    check_eq("par_frame_done", 16'(fd_ok), 16'd1);
    @(negedge clk);
    check_eq("par_back_idle", 16'(st_w[idx]), 16'd0);
  endtask

  // monitor: decode every frame on instance 0 and match against exp_q
  initial begin : monitor
    logic [15:0] bits;
    bit clean, fd_ok, ab;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (!reset && tx_w[0] === 1'b0) begin
        start_q.push_back(cyc);
        capture(0, 10, bits, clean, fd_ok, ab);
        if (!ab) begin
          if (exp_q.size() == 0) begin
            check_eq("frame_unexpected", 16'(exp_q.size()), 16'd1);
          end else begin
            exp = exp_q.pop_front();
            check_eq("frame_data", 16'(bits[8:1]), 16'(exp));
            check_eq("frame_start_bit", 16'(bits[0]), 16'd0);
            check_eq("frame_stop_bit", 16'(bits[9]), 16'd1);
            check_eq("frame_bit_stable", 16'(clean), 16'd1);
            check_eq("frame_done_pulse", 16'(fd_ok), 16'd1);
          end
        end
      end
    end
  end

  initial begin : main
    int bad;
    int k;
    int base;
    int p0;
    int s;

    repeat (3) @(negedge clk);
    check_eq("rst_tx", 16'(tx_w[0]), 16'd1);
    check_eq("rst_busy", 16'(busy_w[0]), 16'd0);
    check_eq("rst_re", 16'(re_w[0]), 16'd0);
    check_eq("rst_frame_done", 16'(fd_w[0]), 16'd0);
    check_eq("rst_state", 16'(st_w[0]), 16'd0);
    reset = 1'b0;

    // empty held high: line must stay quiet
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_w !== 3'b111 || re_w !== 3'b000 || busy_w !== 3'b000 || fd_w !== 3'b000) bad++;
    end
    check_eq("idle_quiet", 16'(bad), 16'd0);

    // single word 0xA5 with start latency
    k = cyc;
    push(8'hA5);
    wait_starts(1, "a5_start_seen");
    check_eq("start_latency", 16'(start_q[0] - k), 16'd3);
    wait_idle("a5_drained");
    check_eq("a5_pops", 16'(pop_cnt), 16'd1);

    // three back-to-back frames
    base = start_q.size();
    p0 = pop_cnt;
    push(8'h01); push(8'hFF); push(8'h00);
    wait_starts(base + 3, "b2b_starts_seen");
    check_eq("b2b_gap0", 16'(start_q[base + 1] - start_q[base]), 16'd42);
    check_eq("b2b_gap1", 16'(start_q[base + 2] - start_q[base + 1]), 16'd42);
    wait_idle("b2b_drained");
    check_eq("b2b_pops", 16'(pop_cnt - p0), 16'd3);
    check_eq("b2b_empty", 16'(empty0), 16'd1);
    check_eq("b2b_state_idle", 16'(st_w[0]), 16'd0);

    // parity variants on 0x07
    parity_frame(1, 1'b1);
    parity_frame(2, 1'b0);

    // reset during data bit 3 of 0x3C, 0x55 still queued
    base = start_q.size();
    p0 = pop_cnt;
    push(8'h3C); push(8'h55);
    wait_starts(base + 1, "rst_frame_start_seen");
    s = start_q[base];
    while (cyc < s + 4 + 12 + 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_tx", 16'(tx_w[0]), 16'd1);
    check_eq("midrst_busy", 16'(busy_w[0]), 16'd0);
    check_eq("midrst_state", 16'(st_w[0]), 16'd0);
    check_eq("midrst_re", 16'(re_w[0]), 16'd0);
    check_eq("midrst_pops", 16'(pop_cnt - p0), 16'd1);
    reset = 1'b0;
    void'(exp_q.pop_front());
    wait_starts(base + 2, "post_rst_start_seen");
    wait_idle("post_rst_drained");
    check_eq("post_rst_pops", 16'(pop_cnt - p0), 16'd2);

    // random pushes while draining
    repeat (16) begin
      push(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_idle("rand_drained");
    check_eq("rand_all_popped", 16'(pop_cnt), 16'(push_cnt));
    check_eq("scoreboard_empty", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
